// File: rtl/max_pkg.sv
// Shared definitions for the max datapath: frame count width, saturation value and lane compare.
// Build option MAX_TRACKER_SIGNED_EN switches every comparison to two's-complement.
package max_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam int CMP_W = 64;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } acc_state_e;

    // Operands are left-aligned into CMP_W bits so one function serves any WIDTH up to CMP_W.
    function automatic logic max_gt(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
`ifdef MAX_TRACKER_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

endpackage

// File: rtl/max_lane_tree.sv
// Combinational LANES-to-1 maximum with lane index; balanced pairwise tree, lowest lane wins ties.
// Signedness follows MAX_TRACKER_SIGNED_EN through max_pkg::max_gt.
module max_lane_tree
    import max_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int IDXW = $clog2(LANES)
) (
    input  logic [LANES*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]       max_o,
    output logic [IDXW-1:0]        lane_o
);

    function automatic logic [CMP_W-1:0] align(input logic [WIDTH-1:0] x);
        return CMP_W'(x) << (CMP_W - WIDTH);
    endfunction

    genvar l, j;
    generate
        for (l = 0; l <= IDXW; l++) begin : g_lvl
            localparam int N = LANES >> l;
            logic [WIDTH-1:0] m  [N];
            logic [IDXW-1:0]  ix [N];
            for (j = 0; j < N; j++) begin : g_node
                if (l == 0) begin : g_leaf
                    assign m[j]  = data_i[j*WIDTH +: WIDTH];
                    assign ix[j] = IDXW'(j);
                end else begin : g_cmp
                    // The upper-lane child only wins on a strict greater-than.
                    logic takeHi;
                    assign takeHi = max_gt(align(g_lvl[l-1].m[2*j+1]), align(g_lvl[l-1].m[2*j]));
                    assign m[j]   = takeHi ? g_lvl[l-1].m[2*j+1]  : g_lvl[l-1].m[2*j];
                    assign ix[j]  = takeHi ? g_lvl[l-1].ix[2*j+1] : g_lvl[l-1].ix[2*j];
                end
            end
        end
    endgenerate

    assign max_o  = g_lvl[IDXW].m[0];
    assign lane_o = g_lvl[IDXW].ix[0];

endmodule

// File: rtl/max_tracker.sv
// Streaming frame maximum: per-beat lane reduce, then a running max/lane/count per in_last frame.
// Build option MAX_TRACKER_SIGNED_EN selects signed lane words.
module max_tracker
    import max_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int IDXW = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_max,
    output logic [IDXW-1:0]        out_lane,
    output logic [CNT_W-1:0]       out_count
);

    function automatic logic [CMP_W-1:0] align(input logic [WIDTH-1:0] x);
        return CMP_W'(x) << (CMP_W - WIDTH);
    endfunction

    logic [WIDTH-1:0] treeMax;
    logic [IDXW-1:0]  treeLane;

    max_lane_tree #(.WIDTH(WIDTH), .LANES(LANES)) u_tree (
        .data_i (in_data),
        .max_o  (treeMax),
        .lane_o (treeLane)
    );

    logic             s1Valid_q, s1Last_q;
    logic [WIDTH-1:0] s1Max_q;
    logic [IDXW-1:0]  s1Lane_q;
    logic             outValid_q;
    logic [WIDTH-1:0] outMax_q;
    logic [IDXW-1:0]  outLane_q;
    logic [CNT_W-1:0] outCnt_q;
    logic             s1Advance, beat, emit;

    // Only a closing beat can stall, and only while an unconsumed result is still held.
    assign s1Advance = ~(s1Valid_q & s1Last_q & outValid_q & ~out_ready);
    assign in_ready  = ~s1Valid_q | s1Advance;
    assign beat      = s1Valid_q & s1Advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Max_q   <= '0;
            s1Lane_q  <= '0;
        end else if (in_ready) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Last_q <= in_last;
                s1Max_q  <= treeMax;
                s1Lane_q <= treeLane;
            end
        end
    end

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] accMax_q, accMax_d;
    logic [IDXW-1:0]  accLane_q, accLane_d;
    logic [CNT_W-1:0] accCnt_q, accCnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (beat && !s1Last_q) state_d = ST_ACC;
            ST_ACC:  if (beat && s1Last_q)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accMax_d  = accMax_q;
        accLane_d = accLane_q;
        accCnt_d  = accCnt_q;
        emit      = 1'b0;
        if (beat) begin
            emit = s1Last_q;
            if (state_q == ST_IDLE) begin
                accMax_d  = s1Max_q;
                accLane_d = s1Lane_q;
                accCnt_d  = CNT_W'(1);
            end else begin
                if (max_gt(align(s1Max_q), align(accMax_q))) begin
                    accMax_d  = s1Max_q;
                    accLane_d = s1Lane_q;
                end
                if (accCnt_q != CNT_SAT) accCnt_d = accCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accMax_q  <= '0;
            accLane_q <= '0;
            accCnt_q  <= '0;
        end else begin
            accMax_q  <= accMax_d;
            accLane_q <= accLane_d;
            accCnt_q  <= accCnt_d;
        end
    end

    // A new result may land in the same cycle the previous one is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outMax_q   <= '0;
            outLane_q  <= '0;
            outCnt_q   <= '0;
        end else if (emit) begin
            outValid_q <= 1'b1;
            outMax_q   <= accMax_d;
            outLane_q  <= accLane_d;
            outCnt_q   <= accCnt_d;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign out_max   = outMax_q;
    assign out_lane  = outLane_q;
    assign out_count = outCnt_q;

endmodule
